// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and types for the EXE-stage forwarding / load-use hazard unit.
package fwd_hazard_unit_pkg;

    localparam int REG_ADDR_LEN_DEF = 5;
    localparam int SEL_RF           = 0;
    localparam int SEL_STAGE_BASE   = 1;
    localparam int FORW_SEL_LEN     = 2;
    localparam int STALL_CNT_LEN    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_t;

endpackage

// File: rtl/fwd_match_prio.sv
// Per-source forwarding match with nearest-stage priority; flags a load-use hazard
// when the winning producer is still a load in flight.
module fwd_match_prio
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
    parameter int NUM_STAGES   = 2,
    parameter int SEL_LEN      = $clog2(NUM_STAGES + 1),
    parameter int ZERO_REG_FWD = 0
) (
    input  logic [REG_ADDR_LEN-1:0]            src_addr,
    input  logic                               src_valid,
    input  logic [NUM_STAGES*REG_ADDR_LEN-1:0] dest_addr,
    input  logic [NUM_STAGES-1:0]              dest_wb_en,
    input  logic [NUM_STAGES-1:0]              dest_is_load,
    output logic [SEL_LEN-1:0]                 sel,
    output logic                               hazard
);

    logic addr_ok;

    assign addr_ok = (ZERO_REG_FWD != 0) || (src_addr != '0);

    // Walk from the farthest stage inward so the nearest match overwrites the rest.
    always_comb begin
        sel    = SEL_LEN'(SEL_RF);
        hazard = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (src_valid && addr_ok && dest_wb_en[k] &&
                (src_addr == dest_addr[k*REG_ADDR_LEN +: REG_ADDR_LEN])) begin
                sel    = SEL_LEN'(k + SEL_STAGE_BASE);
                hazard = dest_is_load[k];
            end
        end
        if (hazard) begin
            sel = SEL_LEN'(SEL_RF);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EXE-stage operand forwarding select generator with load-use stall FSM,
// synchronous flush and a saturating forward-event counter.
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_LEN = REG_ADDR_LEN_DEF,
    parameter int NUM_SRC      = 3,
    parameter int NUM_STAGES   = 2,
    parameter int SEL_LEN      = $clog2(NUM_STAGES + 1),
    parameter int ZERO_REG_FWD = 0,
    parameter int LOAD_LAT     = 1,
    parameter int CNT_LEN      = 16
) (
    input  logic                               CLK,
    input  logic                               RST_N,
    input  logic [NUM_SRC*REG_ADDR_LEN-1:0]    SRC_ADDR_EXE,
    input  logic [NUM_SRC-1:0]                 SRC_VALID_EXE,
    input  logic [NUM_STAGES*REG_ADDR_LEN-1:0] DEST_ADDR,
    input  logic [NUM_STAGES-1:0]              DEST_WB_EN,
    input  logic [NUM_STAGES-1:0]              DEST_IS_LOAD,
    input  logic                               FLUSH,
    output logic [NUM_SRC*SEL_LEN-1:0]         OPERAND_SEL,
    output logic                               STALL,
    output logic [CNT_LEN-1:0]                 FWD_COUNT
);

    logic [NUM_SRC*SEL_LEN-1:0] sel_raw;
    logic [NUM_SRC*SEL_LEN-1:0] sel_next;
    logic [NUM_SRC-1:0]         hazard_src;
    fsm_state_t                 state, state_next;
    logic [STALL_CNT_LEN-1:0]   stall_cnt, stall_cnt_next;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_match_prio #(
            .REG_ADDR_LEN (REG_ADDR_LEN),
            .NUM_STAGES   (NUM_STAGES),
            .SEL_LEN      (SEL_LEN),
            .ZERO_REG_FWD (ZERO_REG_FWD)
        ) u_match (
            .src_addr     (SRC_ADDR_EXE[i*REG_ADDR_LEN +: REG_ADDR_LEN]),
            .src_valid    (SRC_VALID_EXE[i]),
            .dest_addr    (DEST_ADDR),
            .dest_wb_en   (DEST_WB_EN),
            .dest_is_load (DEST_IS_LOAD),
            .sel          (sel_raw[i*SEL_LEN +: SEL_LEN]),
            .hazard       (hazard_src[i])
        );
    end

    // Flush overrides everything; while stalled no new hazard is accepted.
    always_comb begin
        state_next     = state;
        stall_cnt_next = stall_cnt;
        sel_next       = sel_raw;
        if (FLUSH) begin
            state_next     = ST_IDLE;
            stall_cnt_next = '0;
            sel_next       = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|hazard_src) begin
                        state_next     = ST_STALL;
                        stall_cnt_next = STALL_CNT_LEN'(LOAD_LAT - 1);
                    end
                end
                ST_STALL: begin
                    sel_next = '0;
                    if (stall_cnt == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        stall_cnt_next = stall_cnt - STALL_CNT_LEN'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= ST_IDLE;
            stall_cnt   <= '0;
            OPERAND_SEL <= '0;
            FWD_COUNT   <= '0;
        end else begin
            state       <= state_next;
            stall_cnt   <= stall_cnt_next;
            OPERAND_SEL <= sel_next;
            if ((|sel_next) && (FWD_COUNT != '1)) begin
                FWD_COUNT <= FWD_COUNT + CNT_LEN'(1);
            end
        end
    end

    assign STALL = (state == ST_STALL);

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Randomized and directed bench for fwd_hazard_unit, two parameter sets side by side.
module tb_fwd_hazard_unit;

    localparam int AW = 5;
    localparam int NSRC [2] = '{3, 4};
    localparam int NSTG [2] = '{2, 3};
    localparam int ZF   [2] = '{0, 1};
    localparam int LAT  [2] = '{2, 3};
    localparam int CMAX [2] = '{65535, 7};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] sa [2][4];
    logic [3:0]    sv [2];
    logic [AW-1:0] da [2][3];
    logic [2:0]    we [2];
    logic [2:0]    ld [2];
    logic          fl [2];

    logic [3*AW-1:0] a_src;
    logic [2:0]      a_val;
    logic [2*AW-1:0] a_da;
    logic [1:0]      a_we, a_ld;
    logic [5:0]      a_sel;
    logic            a_stall;
    logic [15:0]     a_cnt;

    logic [4*AW-1:0] b_src;
    logic [3:0]      b_val;
    logic [3*AW-1:0] b_da;
    logic [2:0]      b_we, b_ld;
    logic [7:0]      b_sel;
    logic            b_stall;
    logic [2:0]      b_cnt;

    assign a_src = {sa[0][2], sa[0][1], sa[0][0]};
    assign a_val = sv[0][2:0];
    assign a_da  = {da[0][1], da[0][0]};
    assign a_we  = we[0][1:0];
    assign a_ld  = ld[0][1:0];
    assign b_src = {sa[1][3], sa[1][2], sa[1][1], sa[1][0]};
    assign b_val = sv[1];
    assign b_da  = {da[1][2], da[1][1], da[1][0]};
    assign b_we  = we[1];
    assign b_ld  = ld[1];

    fwd_hazard_unit #(
        .REG_ADDR_LEN(AW), .NUM_SRC(3), .NUM_STAGES(2),
        .ZERO_REG_FWD(0), .LOAD_LAT(2), .CNT_LEN(16)
    ) dut_a (
        .CLK(clk), .RST_N(rst_n), .SRC_ADDR_EXE(a_src), .SRC_VALID_EXE(a_val),
        .DEST_ADDR(a_da), .DEST_WB_EN(a_we), .DEST_IS_LOAD(a_ld), .FLUSH(fl[0]),
        .OPERAND_SEL(a_sel), .STALL(a_stall), .FWD_COUNT(a_cnt)
    );

    fwd_hazard_unit #(
        .REG_ADDR_LEN(AW), .NUM_SRC(4), .NUM_STAGES(3),
        .ZERO_REG_FWD(1), .LOAD_LAT(3), .CNT_LEN(3)
    ) dut_b (
        .CLK(clk), .RST_N(rst_n), .SRC_ADDR_EXE(b_src), .SRC_VALID_EXE(b_val),
        .DEST_ADDR(b_da), .DEST_WB_EN(b_we), .DEST_IS_LOAD(b_ld), .FLUSH(fl[1]),
        .OPERAND_SEL(b_sel), .STALL(b_stall), .FWD_COUNT(b_cnt)
    );

    int total = 0;
    int bad   = 0;
    int m_sel [2][4];
    int m_rem [2];
    int m_cnt [2];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) m_sel[d][i] = 0;
            m_rem[d] = 0;
            m_cnt[d] = 0;
        end
    endtask

    // Reference: first matching stage (ascending) wins; m_rem counts stall cycles still owed.
    task automatic model_step(input int d);
        int  nxt [4];
        int  win;
        bit  haz;
        bit  any;
        haz = 0;
        any = 0;
        for (int i = 0; i < 4; i++) nxt[i] = 0;
        for (int i = 0; i < NSRC[d]; i++) begin
            win = -1;
            for (int k = 0; k < NSTG[d]; k++) begin
                if (win < 0 && sv[d][i] && we[d][k] && sa[d][i] == da[d][k] &&
                    (ZF[d] != 0 || sa[d][i] != 0))
                    win = k;
            end
            if (win >= 0) begin
                if (ld[d][win]) haz = 1;
                else nxt[i] = win + 1;
            end
        end
        if (fl[d]) begin
            for (int i = 0; i < 4; i++) nxt[i] = 0;
            m_rem[d] = 0;
        end else if (m_rem[d] > 0) begin
            for (int i = 0; i < 4; i++) nxt[i] = 0;
            m_rem[d] = m_rem[d] - 1;
        end else if (haz) begin
            m_rem[d] = LAT[d];
        end
        for (int i = 0; i < 4; i++) begin
            if (nxt[i] != 0) any = 1;
            m_sel[d][i] = nxt[i];
        end
        if (any && m_cnt[d] < CMAX[d]) m_cnt[d] = m_cnt[d] + 1;
    endtask

    task automatic check_outs(input string tag);
        for (int i = 0; i < NSRC[0]; i++)
            chk($sformatf("%s a.sel%0d", tag, i), 32'(a_sel[i*2 +: 2]), 32'(m_sel[0][i]));
        chk($sformatf("%s a.stall", tag), 32'(a_stall), 32'(m_rem[0] > 0));
        chk($sformatf("%s a.cnt", tag), 32'(a_cnt), 32'(m_cnt[0]));
        for (int i = 0; i < NSRC[1]; i++)
            chk($sformatf("%s b.sel%0d", tag, i), 32'(b_sel[i*2 +: 2]), 32'(m_sel[1][i]));
        chk($sformatf("%s b.stall", tag), 32'(b_stall), 32'(m_rem[1] > 0));
        chk($sformatf("%s b.cnt", tag), 32'(b_cnt), 32'(m_cnt[1]));
    endtask

    task automatic step(input string tag);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_outs(tag);
    endtask

    task automatic clear_in();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 4; i++) sa[d][i] = '0;
            for (int k = 0; k < 3; k++) da[d][k] = '0;
            sv[d] = '0;
            we[d] = '0;
            ld[d] = '0;
            fl[d] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit pat [6] = '{1, 1, 0, 1, 1, 0};
        rst_n = 1'b0;
        clear_in();
        model_reset();
        #12;
        check_outs("reset");
        rst_n = 1'b1;

        // Nearest stage wins over WB for the same address.
        sa[0][0] = 5; sv[0] = 3'b001; da[0][0] = 5; da[0][1] = 5; we[0] = 3'b011;
        step("near");
        chk("near_sel", 32'(a_sel[1:0]), 1);
        chk("near_cnt", 32'(a_cnt), 1);

        // Register 0: masked in A, forwarded in B.
        clear_in();
        sv[0] = 3'b010; we[0] = 3'b001;
        sv[1] = 4'b0010; we[1] = 3'b001;
        step("zero");
        chk("zero_a_sel", 32'(a_sel[3:2]), 0);
        chk("zero_a_cnt", 32'(a_cnt), 1);
        chk("zero_b_sel", 32'(b_sel[3:2]), 1);

        // Load-use on src2 with LOAD_LAT=2, dependency held: repeated 2-cycle stalls.
        clear_in();
        sa[0][2] = 7; sv[0] = 3'b100; da[0][0] = 7; we[0] = 3'b001; ld[0] = 3'b001;
        for (int j = 0; j < 6; j++) begin
            step("ldu");
            chk("ldu_stall", 32'(a_stall), 32'(pat[j]));
            chk("ldu_sel", 32'(a_sel), 0);
        end

        // Hazard with flush in the same cycle, then flush mid-stall.
        fl[0] = 1'b1;
        step("hz_flush");
        chk("hz_flush_stall", 32'(a_stall), 0);
        fl[0] = 1'b0;
        step("hz_enter");
        chk("hz_enter_stall", 32'(a_stall), 1);
        fl[0] = 1'b1;
        step("mid_flush");
        chk("mid_flush_stall", 32'(a_stall), 0);
        clear_in();
        step("idle1");
        step("idle2");

        // B: src3 only matches stage 2, src0 matches stage 0 but is not valid; counter saturates.
        sa[1][3] = 9; sa[1][0] = 4; sv[1] = 4'b1000;
        da[1][2] = 9; da[1][0] = 4; we[1] = 3'b101;
        for (int j = 0; j < 10; j++) step("sat");
        chk("sat_cnt", 32'(b_cnt), 7);
        chk("stg2_sel", 32'(b_sel[7:6]), 3);
        chk("noval_sel", 32'(b_sel[1:0]), 0);

        // Async reset in the middle of a B stall.
        ld[1] = 3'b100;
        step("b_hz");
        chk("b_hz_stall", 32'(b_stall), 1);
        step("b_hz2");
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outs("async_rst");
        chk("async_rst_stall", 32'(b_stall), 0);
        chk("async_rst_cnt", 32'(b_cnt), 0);
        @(posedge clk);
        #1;
        check_outs("rst_hold");
        rst_n = 1'b1;
        clear_in();

        // Random traffic on a small address range so matches and hazards are frequent.
        for (int n = 0; n < 400; n++) begin
            for (int d = 0; d < 2; d++) begin
                for (int i = 0; i < 4; i++) sa[d][i] = AW'($urandom_range(0, 3));
                for (int k = 0; k < 3; k++) da[d][k] = AW'($urandom_range(0, 3));
                sv[d] = 4'($urandom);
                we[d] = 3'($urandom);
                ld[d] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
                fl[d] = ($urandom_range(0, 9) == 0);
            end
            step("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised successor to the EXE-stage forwarding select generator.
- Resolves operand forwarding for NUM_SRC EXE-stage source registers against NUM_STAGES downstream destination stages, with nearest-stage priority and zero-register masking.
- Adds load-use hazard detection with a timed stall FSM, a synchronous flush, and a saturating forward-event counter.
- Sits between the EXE stage operand muxes and the pipeline stall/flush control.

Parameters:
- REG_ADDR_LEN, 5: register address width.
- NUM_SRC, 3: number of EXE source operands (ALU op1, ALU op2, store data).
- NUM_STAGES, 2: number of forwarding stages. Index 0 is the nearest stage (MEM), index 1 is WB, and so on.
- SEL_LEN, $clog2(NUM_STAGES+1): width of each select field.
- ZERO_REG_FWD, 0: when 0, address 0 never matches.
- LOAD_LAT, 1: number of stall cycles per load-use hazard, 1..15.
- CNT_LEN, 16: width of the forward-event counter.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- SRC_ADDR_EXE  in  NUM_SRC*REG_ADDR_LEN  source addresses; source i occupies slice i.
- SRC_VALID_EXE  in  NUM_SRC  source i is actually read.
- DEST_ADDR  in  NUM_STAGES*REG_ADDR_LEN  destination address per stage.
- DEST_WB_EN  in  NUM_STAGES  write-back enable per stage.
- DEST_IS_LOAD  in  NUM_STAGES  the stage's result is not yet available (load in flight).
- FLUSH  in  1  synchronous pipeline flush.
- OPERAND_SEL  out  NUM_SRC*SEL_LEN  registered select per source. 0 = register file; k+1 = stage k.
- STALL  out  1  registered stall request.
- FWD_COUNT  out  CNT_LEN  saturating count of cycles with any nonzero select.

Behaviour:
- Reset (RST_N low, asynchronous):
  - OPERAND_SEL = 0, STALL = 0, FWD_COUNT = 0.
  - FSM = IDLE, stall counter = 0.
- Match rule, evaluated per source i and stage k:
  - A match requires SRC_VALID_EXE[i], DEST_WB_EN[k], and SRC_ADDR_EXE[i] == DEST_ADDR[k].
  - If ZERO_REG_FWD = 0, an address of 0 never matches.
- Priority: the lowest matching k wins, so the youngest producer takes precedence.
- Select latency: the select computed from cycle-t inputs appears on OPERAND_SEL after the edge ending cycle t (1-cycle registered latency).
- Load-use hazard: the winning match for any source has DEST_IS_LOAD[k] = 1.
  - That source's select is registered as 0.
  - The hazard flags the FSM. Lower-priority stages are not used as a fallback.
- FSM states:
  - IDLE: STALL = 0. On a hazard with FLUSH = 0, go to STALL and load the counter with LOAD_LAT-1.
  - STALL: STALL = 1. Hazard detection is suppressed (no re-trigger), and all selects are registered as 0. When the counter is 0, return to IDLE; otherwise decrement.
  - Detection resumes in the first IDLE cycle, so a still-present dependency re-stalls.
- Stall timing: a hazard in cycle t gives STALL = 1 in cycles t+1 .. t+LOAD_LAT, exactly LOAD_LAT cycles.
- FLUSH (synchronous, highest priority after reset):
  - Next state: OPERAND_SEL = 0, STALL = 0, FSM = IDLE, counter = 0.
  - FWD_COUNT is unaffected.
- Simultaneous hazard and FLUSH: the flush wins and no stall is entered.
- FWD_COUNT:
  - Increments on each edge at which the next OPERAND_SEL is nonzero in any field.
  - Saturates at all-ones, with no wrap.
  - Cleared only by reset.
- Multiple sources hitting the same stage: each gets an independent select. There is no arbitration between sources.
- Reset mid-stall: immediate return to IDLE with STALL = 0.

Decomposition:
- Shared package/defines:
  - REG_ADDR_LEN.
  - Select encodings: SEL_RF = 0, SEL_STAGE_BASE = 1.
  - FSM state encodings: IDLE, STALL.
  - The existing FORW_SEL_LEN equals SEL_LEN for NUM_STAGES = 2.
- One sub-module, fwd_match_prio:
  - Combinational, one instance per source (generate loop).
  - Outputs the winning select and a hazard flag.
  - The top level holds the FSM, the registers and the counter.

Test Plan:
- Default parameters; src0 = 5 valid; stage0 dest 5 WB_EN; stage1 dest 5 WB_EN -> next cycle OPERAND_SEL[src0] = 1 (nearest stage wins), FWD_COUNT = 1.
- src1 = 0 with stage0 dest 0 WB_EN, ZERO_REG_FWD = 0 -> select 0 and count unchanged. Repeat with ZERO_REG_FWD = 1 -> select 1.
- src2 = 7; stage0 dest 7 WB_EN with DEST_IS_LOAD[0] = 1 and LOAD_LAT = 2 -> STALL high for exactly 2 cycles, selects 0 throughout, then IDLE. With inputs unchanged, a new 2-cycle stall follows.
- Hazard and FLUSH in the same cycle -> STALL stays 0 and selects are 0. FLUSH asserted mid-STALL -> STALL drops next cycle.
- CNT_LEN = 3; forward every cycle for 10 cycles -> FWD_COUNT reaches 7 and holds. RST_N pulsed low asynchronously mid-stall -> all outputs 0 immediately.
- NUM_STAGES = 3, NUM_SRC = 4; source 3 matches only stage 2 -> select 3, SEL_LEN = 2; a source with SRC_VALID_EXE = 0 matching stage 0 -> select 0.
